jtopl_wrqueue: RTL and testbench

//  Register-write queue upstream of the OPL2 core's CPU bus (addr/din/cs_n/wr_n).

---
 rtl/jtopl_wrqueue.sv | 217 +++++++++++++++++++++
 tb/tb_jtopl_wrqueue.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_wrqueue.sv
// -----------------------------------------------------------------------------
// jtopl_wrqueue
//
// Purpose
//    Write queue sitting in front of the OPL2 core's CPU bus. The host pushes
//    (register, value) pairs at full clock rate. Each pair is replayed as an
//    address-port write followed by a data-port write. The inter-write waits
//    the OPL2 needs are inserted here and counted in cen ticks, so the host
//    never has to poll the chip or busy-wait.
//
// Parameters
//    AW         FIFO depth is 2**AW entries of {reg[7:0], val[7:0]}
//    ADDR_WAIT  cen ticks idle after the address strobe (1..255)
//    DATA_WAIT  cen ticks idle after the data strobe (1..255)
//
// Ports
//    clk        system clock
//    rst_n      asynchronous active-low reset
//    cen        clock enable shared with the OPL core
//    in_valid   host write request
//    in_ready   FIFO can accept (transfer on in_valid & in_ready at clk edge)
//    in_reg     OPL register index
//    in_val     value for that register
//    flush      discard all queued entries (an in-flight pair still completes)
//    level      entries currently queued, excluding the in-flight pair
//    busy       registered: FSM not idle or entries queued
//    opl_addr   0 = address port, 1 = data port
//    opl_din    byte presented to the core
//    opl_cs_n   chip select to the core (active low)
//    opl_wr_n   write strobe to the core (always equal to opl_cs_n)
// -----------------------------------------------------------------------------
module jtopl_wrqueue #(
   parameter int AW        = 4,
   parameter int ADDR_WAIT = 12,
   parameter int DATA_WAIT = 84
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_reg,
   input  logic [7:0]    in_val,
   input  logic          flush,
   output logic [AW:0]   level,
   output logic          busy,
   output logic          opl_addr,
   output logic [7:0]    opl_din,
   output logic          opl_cs_n,
   output logic          opl_wr_n
);

   localparam int         DEPTH     = 1 << AW;
   localparam logic [7:0] ADDR_LAST = 8'(ADDR_WAIT - 1);
   localparam logic [7:0] DATA_LAST = 8'(DATA_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASTB,
      ST_AWAIT,
      ST_DSTB,
      ST_DWAIT
   } state_t;

   // ---------------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------------
   logic [15:0]   mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_d;
   logic [15:0]   rd_word;
   logic          full;
   logic          empty;
   logic          push_ok;
   logic          pop;

   // FSM state and registered outputs
   state_t        state_q;
   logic [7:0]    cnt_q;
   logic [7:0]    val_q;
   logic          opl_addr_q;
   logic [7:0]    opl_din_q;
   logic          opl_cs_n_q;
   logic          busy_q;
   logic          busy_d;
   logic          idle_next;

   // Full when the indices match but the wrap bits differ.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   // A push during flush is dropped; ready is purely a function of the
   // registered pointers so a same-cycle pop cannot make room for a push.
   assign push_ok = in_valid && !full && !flush;

   // Pops only start a new pair from IDLE; flush wins so a discarded entry
   // never reaches the bus.
   assign pop = (state_q == ST_IDLE) && !empty && !flush;

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
   assign rd_ptr_d = flush ? wr_ptr_q : (rd_ptr_q + {{AW{1'b0}}, pop});
   assign level_d  = wr_ptr_d - rd_ptr_d;

   assign rd_word  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {in_reg, in_val};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // busy tracks the state the FSM will be in after this edge, so it drops in
   // the first IDLE cycle following DWAIT when nothing is left queued.
   // ---------------------------------------------------------------------------
   always_comb begin
      idle_next = 1'b0;
      if (state_q == ST_IDLE && !pop) begin
         idle_next = 1'b1;
      end else if (state_q == ST_DWAIT && cen && cnt_q == DATA_LAST) begin
         idle_next = 1'b1;
      end
      busy_d = !idle_next || (level_d != '0);
   end

   // ---------------------------------------------------------------------------
   // Write sequencer. Outputs are set on the transition into each state so the
   // bus sees clean registered strobes. Each strobe is held until a cen cycle,
   // which guarantees the core samples exactly one write per strobe.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         val_q      <= '0;
         opl_addr_q <= 1'b0;
         opl_din_q  <= '0;
         opl_cs_n_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         busy_q <= busy_d;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  state_q    <= ST_ASTB;
                  val_q      <= rd_word[7:0];
                  opl_addr_q <= 1'b0;
                  opl_din_q  <= rd_word[15:8];
                  opl_cs_n_q <= 1'b0;
               end
            end
            ST_ASTB: begin
               if (cen) begin
                  state_q    <= ST_AWAIT;
                  cnt_q      <= '0;
                  opl_cs_n_q <= 1'b1;
               end
            end
            ST_AWAIT: begin
               // opl_din keeps the register index while waiting.
               if (cen) begin
                  if (cnt_q == ADDR_LAST) begin
                     state_q    <= ST_DSTB;
                     opl_addr_q <= 1'b1;
                     opl_din_q  <= val_q;
                     opl_cs_n_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            ST_DSTB: begin
               if (cen) begin
                  state_q    <= ST_DWAIT;
                  cnt_q      <= '0;
                  opl_cs_n_q <= 1'b1;
               end
            end
            ST_DWAIT: begin
               if (cen) begin
                  if (cnt_q == DATA_LAST) begin
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               opl_cs_n_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready = !full;
   assign level    = wr_ptr_q - rd_ptr_q;
   assign busy     = busy_q;
   assign opl_addr = opl_addr_q;
   assign opl_din  = opl_din_q;
   // One register drives both strobes so they can never disagree.
   assign opl_cs_n = opl_cs_n_q;
   assign opl_wr_n = opl_cs_n_q;

endmodule

// File: tb/tb_jtopl_wrqueue.sv
// -----------------------------------------------------------------------------
// tb_jtopl_wrqueue
//
// Purpose
//    Self-checking bench for jtopl_wrqueue. A negedge monitor logs every bus
//    strobe (start/end cycle, addr/din, wr_n). Expected strobes are queued when
//    pairs are pushed and are popped and compared as the logged strobes are
//    drained. Timing of strobes and busy is checked against cycle arithmetic.
// -----------------------------------------------------------------------------
module tb_jtopl_wrqueue;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cen;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_reg = 8'h00;
   logic [7:0]    in_val = 8'h00;
   logic          flush = 1'b0;
   logic [AW:0]   level;
   logic          busy;
   logic          opl_addr;
   logic [7:0]    opl_din;
   logic          opl_cs_n;
   logic          opl_wr_n;

   int            cyc = 0;
   int            cen_mode = 0;   // 0: cen low, 1: cen high, 2: cen 1 clk in 4

   assign cen = (cen_mode == 1) || (cen_mode == 2 && (cyc % 4) == 0);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   jtopl_wrqueue #(.AW(AW), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_reg   (in_reg),
      .in_val   (in_val),
      .flush    (flush),
      .level    (level),
      .busy     (busy),
      .opl_addr (opl_addr),
      .opl_din  (opl_din),
      .opl_cs_n (opl_cs_n),
      .opl_wr_n (opl_wr_n)
   );

   // ---------------------------------------------------------------------------
   // Strobe monitor
   // ---------------------------------------------------------------------------
   int            st_start [256];
   int            st_end   [256];
   logic [8:0]    st_data  [256];
   logic          st_wr    [256];
   int            st_n = 0;
   int            busy_fall = -1;
   logic          cs_prev = 1'b1;
   logic          busy_prev = 1'b0;

   always @(negedge clk) begin
      if (opl_cs_n === 1'b0 && cs_prev === 1'b1 && st_n < 256) begin
         st_start[st_n] <= cyc;
         st_end[st_n]   <= -1;
         st_data[st_n]  <= {opl_addr, opl_din};
         st_wr[st_n]    <= opl_wr_n;
         st_n           <= st_n + 1;
      end
      if (opl_cs_n === 1'b1 && cs_prev === 1'b0 && st_n > 0) begin
         st_end[st_n-1] <= cyc;
      end
      if (busy === 1'b0 && busy_prev === 1'b1) begin
         busy_fall <= cyc;
      end
      cs_prev   <= opl_cs_n;
      busy_prev <= busy;
   end

   // ---------------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------------
   int            checks = 0;
   int            errors = 0;
   logic [8:0]    sb [$];
   int            drain_idx = 0;

   typedef struct {
      logic [7:0] r;
      logic [7:0] v;
      int         exp_ready;
      int         exp_level;
   } vec_t;

   vec_t          vecs [17];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic push(input logic [7:0] r, input logic [7:0] v, input bit keep);
      in_valid = 1'b1;
      in_reg   = r;
      in_val   = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (keep) begin
         sb.push_back({1'b0, r});
         sb.push_back({1'b1, v});
      end
   endtask

   task automatic wait_strobes(input int n, input int budget);
      int k;
      k = 0;
      while (st_n < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk("strobe_count_reached", (st_n >= n) ? 1 : 0, 1);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk("busy_low", int'(busy), 0);
      // let the monitor log the busy edge
      @(posedge clk); #1;
   endtask

   // Compare every newly logged strobe against the scoreboard, in order.
   task automatic drain();
      logic [8:0] e;
      while (drain_idx < st_n) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got 0x%0h expected none", st_data[drain_idx]);
         end else begin
            e = sb.pop_front();
            chk($sformatf("strobe%0d_addr_din", drain_idx), int'(st_data[drain_idx]), int'(e));
         end
         chk($sformatf("strobe%0d_wr_n", drain_idx), int'(st_wr[drain_idx]), 0);
         drain_idx++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      int base;
      int n0;

      for (int i = 0; i < 17; i++) begin
         vecs[i].r         = 8'(8'h50 + i);
         vecs[i].v         = 8'(i * 7 + 3);
         vecs[i].exp_ready = (i < 16) ? 1 : 0;
         vecs[i].exp_level = (i < 16) ? (i + 1) : 16;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n",     int'(opl_cs_n), 1);
      chk("rst_wr_n",     int'(opl_wr_n), 1);
      chk("rst_addr",     int'(opl_addr), 0);
      chk("rst_din",      int'(opl_din), 0);
      chk("rst_busy",     int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_level",    int'(level), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: single pair, cen=1, exact timing
      cen_mode = 1;
      base = st_n;
      push(8'h20, 8'h01, 1'b1);
      wait_strobes(base + 2, 300);
      wait_idle(300);
      chk("t1_astb_len",  st_end[base] - st_start[base], 1);
      chk("t1_addr_gap",  st_start[base+1] - st_end[base], 12);
      chk("t1_dstb_len",  st_end[base+1] - st_start[base+1], 1);
      chk("t1_busy_fall", busy_fall - st_start[base+1], 85);
      drain();
      chk("t1_sb_empty", sb.size(), 0);

      // 2: fill the FIFO while the first pair is stuck in ASTB (cen=0)
      cen_mode = 0;
      base = st_n;
      push(8'h40, 8'h55, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("t2_level_after_pop", int'(level), 0);
      chk("t2_astb_held",       int'(opl_cs_n), 0);
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("t2_ready%0d", i), int'(in_ready), vecs[i].exp_ready);
         in_valid = 1'b1;
         in_reg   = vecs[i].r;
         in_val   = vecs[i].v;
         @(posedge clk); #1;
         chk($sformatf("t2_level%0d", i), int'(level), vecs[i].exp_level);
         if (vecs[i].exp_ready != 0) begin
            sb.push_back({1'b0, vecs[i].r});
            sb.push_back({1'b1, vecs[i].v});
         end
      end
      in_valid = 1'b0;
      chk("t2_ready_full", int'(in_ready), 0);
      cen_mode = 1;
      wait_strobes(base + 34, 4000);
      wait_idle(400);
      drain();
      chk("t2_sb_empty", sb.size(), 0);

      // 3: cen one clock in four
      cen_mode = 2;
      base = st_n;
      push(8'hA0, 8'h11, 1'b1);
      push(8'hA1, 8'h22, 1'b1);
      wait_strobes(base + 4, 3000);
      wait_idle(1000);
      chk_range("t3_astb_len",  st_end[base] - st_start[base], 1, 4);
      chk_range("t3_dstb_len",  st_end[base+1] - st_start[base+1], 1, 4);
      chk_range("t3_addr_gap",  st_start[base+1] - st_end[base], 45, 51);
      chk_range("t3_data_gap",  st_start[base+2] - st_end[base+1], 336, 345);
      drain();
      chk("t3_sb_empty", sb.size(), 0);

      // 4: async reset during DWAIT with 5 entries queued
      cen_mode = 1;
      base = st_n;
      push(8'h30, 8'h9C, 1'b1);
      for (int i = 0; i < 5; i++) begin
         push(8'(8'h31 + i), 8'(8'hC0 + i), 1'b0);
      end
      wait_strobes(base + 2, 300);
      repeat (10) @(posedge clk);
      #1;
      chk("t4_level_before", int'(level), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t4_cs_n_async",  int'(opl_cs_n), 1);
      chk("t4_wr_n_async",  int'(opl_wr_n), 1);
      chk("t4_addr_async",  int'(opl_addr), 0);
      chk("t4_din_async",   int'(opl_din), 0);
      chk("t4_busy_async",  int'(busy), 0);
      chk("t4_level_async", int'(level), 0);
      chk("t4_ready_async", int'(in_ready), 1);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      n0 = st_n;
      repeat (300) @(posedge clk);
      #1;
      chk("t4_no_strobes", st_n - n0, 0);
      chk("t4_level_after", int'(level), 0);
      drain();
      chk("t4_sb_empty", sb.size(), 0);

      // 5: flush during AWAIT of the first of three
      base = st_n;
      push(8'h60, 8'hA1, 1'b1);
      push(8'h61, 8'hA2, 1'b0);
      push(8'h62, 8'hA3, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_level_before", int'(level), 2);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("t5_level_flushed", int'(level), 0);
      wait_strobes(base + 2, 300);
      wait_idle(300);
      chk("t5_busy_fall", busy_fall - st_start[base+1], 85);
      n0 = st_n;
      repeat (200) @(posedge clk);
      #1;
      chk("t5_no_more", st_n - n0, 0);
      drain();
      chk("t5_sb_empty", sb.size(), 0);

      // 6: push in the same cycle as a pop
      base = st_n;
      in_valid = 1'b1;
      in_reg   = 8'h70;
      in_val   = 8'hB1;
      @(posedge clk); #1;
      in_reg   = 8'h71;
      in_val   = 8'hB2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t6_level_kept", int'(level), 1);
      sb.push_back({1'b0, 8'h70});
      sb.push_back({1'b1, 8'hB1});
      sb.push_back({1'b0, 8'h71});
      sb.push_back({1'b1, 8'hB2});
      wait_strobes(base + 4, 400);
      wait_idle(300);
      chk("t6_pair_gap", st_start[base+2] - st_end[base+1], 85);
      drain();
      chk("t6_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
